// File: rtl/stream_rr_gap_arbiter.sv
// Round-robin arbiter sharing one ready/valid port between NumInp requesters. The grant is held
// until its handshake completes, and a programmable number of idle cycles follows each transfer.
module stream_rr_gap_arbiter #(
    parameter int unsigned NumInp   = 4,
    parameter int unsigned GapWidth = 4,
    parameter type         payload_t = logic,
    localparam int unsigned IdxWidth = (NumInp > 1) ? $clog2(NumInp) : 1
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [GapWidth-1:0] gap_i,
    input  payload_t            inp_payload_i [NumInp],
    input  logic [NumInp-1:0]   inp_valid_i,
    output logic [NumInp-1:0]   inp_ready_o,
    output payload_t            oup_payload_o,
    output logic                oup_valid_o,
    input  logic                oup_ready_i,
    output logic [IdxWidth-1:0] idx_o,
    output logic                busy_o
);

    typedef enum logic [1:0] {StIdle, StLock, StGap} state_e;

    state_e              state_q, state_d;
    logic [IdxWidth-1:0] rr_q, rr_d;
    logic [IdxWidth-1:0] lock_q, lock_d;
    logic [IdxWidth-1:0] last_q, last_d;
    logic [GapWidth-1:0] gap_cnt_q, gap_cnt_d;

    logic                found;
    logic [IdxWidth-1:0] win;
    logic [IdxWidth-1:0] sel;
    logic                valid;
    int unsigned         cand;

    // Scan from rr_q upward, wrapping at NumInp-1 (works for non-power-of-2 NumInp).
    always_comb begin
        found = 1'b0;
        win   = '0;
        cand  = 0;
        for (int unsigned off = 0; off < NumInp; off++) begin
            cand = int'(rr_q) + off;
            if (cand >= NumInp) begin
                cand = cand - NumInp;
            end
            if (!found && inp_valid_i[cand]) begin
                found = 1'b1;
                win   = IdxWidth'(cand);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        lock_d    = lock_q;
        last_d    = last_q;
        gap_cnt_d = gap_cnt_q;
        valid     = 1'b0;
        sel       = last_q;

        case (state_q)
            StIdle: begin
                if (found) begin
                    valid = 1'b1;
                    sel   = win;
                end
            end
            StLock: begin
                valid = 1'b1;
                sel   = lock_q;
            end
            StGap: begin
                if (gap_cnt_q <= GapWidth'(1)) begin
                    state_d = StIdle;
                end else begin
                    gap_cnt_d = gap_cnt_q - GapWidth'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        if (valid) begin
            if (oup_ready_i) begin
                rr_d      = (sel == IdxWidth'(NumInp - 1)) ? '0 : sel + IdxWidth'(1);
                last_d    = sel;
                gap_cnt_d = gap_i;
                state_d   = (gap_i == '0) ? StIdle : StGap;
            end else begin
                lock_d  = sel;
                state_d = StLock;
            end
        end
    end

    always_comb begin
        oup_valid_o      = valid;
        oup_payload_o    = inp_payload_i[sel];
        inp_ready_o      = '0;
        inp_ready_o[sel] = valid & oup_ready_i;
        idx_o            = sel;
        busy_o           = (state_q != StIdle);
        // Outputs are forced quiet for the whole reset, not just after the next edge.
        if (rst_i) begin
            oup_valid_o = 1'b0;
            inp_ready_o = '0;
            idx_o       = '0;
            busy_o      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            rr_q      <= '0;
            lock_q    <= '0;
            last_q    <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            lock_q    <= lock_d;
            last_q    <= last_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // A locked requester must hold valid until its handshake.
    locked_valid_held: assert property (@(posedge clk_i) disable iff (rst_i)
        (state_q == StLock) |-> inp_valid_i[lock_q]);

endmodule

// File: tb/tb_stream_rr_gap_arbiter.sv
// Directed bench for stream_rr_gap_arbiter: a 4-input and a 3-input instance sharing clock/reset.
module tb_stream_rr_gap_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] gap;

    logic [7:0] pay4 [4];
    logic [3:0] v4, r4o;
    logic [7:0] op4;
    logic       ov4, or4, busy4;
    logic [1:0] idx4;

    logic [7:0] pay3 [3];
    logic [2:0] v3, r3o;
    logic [7:0] op3;
    logic       ov3, or3, busy3;
    logic [1:0] idx3;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    stream_rr_gap_arbiter #(.NumInp(4), .GapWidth(4), .payload_t(logic [7:0])) u_dut4 (
        .clk_i(clk), .rst_i(rst), .gap_i(gap),
        .inp_payload_i(pay4), .inp_valid_i(v4), .inp_ready_o(r4o),
        .oup_payload_o(op4), .oup_valid_o(ov4), .oup_ready_i(or4),
        .idx_o(idx4), .busy_o(busy4)
    );

    stream_rr_gap_arbiter #(.NumInp(3), .GapWidth(4), .payload_t(logic [7:0])) u_dut3 (
        .clk_i(clk), .rst_i(rst), .gap_i(gap),
        .inp_payload_i(pay3), .inp_valid_i(v3), .inp_ready_o(r3o),
        .oup_payload_o(op3), .oup_valid_o(ov3), .oup_ready_i(or3),
        .idx_o(idx3), .busy_o(busy3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        v4  = '0;
        or4 = 1'b0;
        v3  = '0;
        or3 = 1'b0;
        gap = '0;
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        v4  = 4'hF;
        or4 = 1'b1;
        #1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", ov4); end
        checks++; if (r4o !== 4'b0) begin errors++; $display("FAIL reset_ready got %b want 0000", r4o); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy4); end
        checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL reset_idx got %0d want 0", idx4); end
        step();
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL reset_valid_edge got %b want 0", ov4); end
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_rdy;
        do_reset();
        gap = 4'd0;
        v4  = 4'hF;
        or4 = 1'b1;
        for (int i = 0; i < 5; i++) begin
            exp_rdy = 4'b0001 << (i % 4);
            #1;
            checks++; if (idx4 !== 2'(i % 4)) begin errors++; $display("FAIL rr_idx cyc %0d got %0d want %0d", i, idx4, i % 4); end
            checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL rr_valid cyc %0d got %b want 1", i, ov4); end
            checks++; if (r4o !== exp_rdy) begin errors++; $display("FAIL rr_ready cyc %0d got %b want %b", i, r4o, exp_rdy); end
            step();
        end
    endtask

    task automatic test_lock();
        do_reset();
        v4  = 4'b0100;
        or4 = 1'b0;
        for (int c = 0; c < 5; c++) begin
            if (c == 2) v4[0] = 1'b1;
            #1;
            checks++; if (idx4 !== 2'd2) begin errors++; $display("FAIL lock_idx cyc %0d got %0d want 2", c, idx4); end
            checks++; if (op4 !== 8'hA2) begin errors++; $display("FAIL lock_payload cyc %0d got %h want a2", c, op4); end
            checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL lock_valid cyc %0d got %b want 1", c, ov4); end
            checks++; if (r4o !== 4'b0) begin errors++; $display("FAIL lock_ready cyc %0d got %b want 0000", c, r4o); end
            checks++; if (busy4 !== (c != 0)) begin errors++; $display("FAIL lock_busy cyc %0d got %b want %b", c, busy4, c != 0); end
            step();
        end
        or4 = 1'b1;
        #1;
        checks++; if (r4o !== 4'b0100) begin errors++; $display("FAIL lock_hs_ready got %b want 0100", r4o); end
        step();
        checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL lock_next_idx got %0d want 0", idx4); end
        checks++; if (op4 !== 8'hA0) begin errors++; $display("FAIL lock_next_payload got %h want a0", op4); end
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL lock_next_valid got %b want 1", ov4); end
    endtask

    task automatic test_gap();
        do_reset();
        v4  = 4'b0010;
        or4 = 1'b1;
        for (int c = 0; c < 9; c++) begin
            // gap changes mid-GAP must be ignored; the value at each handshake is 3
            gap = (c % 4 == 2) ? 4'd1 : 4'd3;
            #1;
            checks++; if (ov4 !== (c % 4 == 0)) begin errors++; $display("FAIL gap_valid cyc %0d got %b want %b", c, ov4, c % 4 == 0); end
            checks++; if (idx4 !== 2'd1) begin errors++; $display("FAIL gap_idx cyc %0d got %0d want 1", c, idx4); end
            checks++; if (busy4 !== (c % 4 != 0)) begin errors++; $display("FAIL gap_busy cyc %0d got %b want %b", c, busy4, c % 4 != 0); end
            step();
        end
    endtask

    task automatic test_wrap();
        do_reset();
        v3  = 3'b010;
        or3 = 1'b1;
        #1;
        checks++; if (idx3 !== 2'd1) begin errors++; $display("FAIL wrap_first_idx got %0d want 1", idx3); end
        checks++; if (r3o !== 3'b010) begin errors++; $display("FAIL wrap_first_ready got %b want 010", r3o); end
        checks++; if (busy3 !== 1'b0) begin errors++; $display("FAIL wrap_busy got %b want 0", busy3); end
        step();
        v3 = 3'b011;
        #1;
        checks++; if (idx3 !== 2'd0) begin errors++; $display("FAIL wrap_idx got %0d want 0", idx3); end
        checks++; if (op3 !== 8'hB0) begin errors++; $display("FAIL wrap_payload got %h want b0", op3); end
        checks++; if (ov3 !== 1'b1) begin errors++; $display("FAIL wrap_valid got %b want 1", ov3); end
        step();
        checks++; if (idx3 !== 2'd1) begin errors++; $display("FAIL wrap_after_idx got %0d want 1", idx3); end
        step();
        checks++; if (idx3 !== 2'd0) begin errors++; $display("FAIL wrap_again_idx got %0d want 0", idx3); end
    endtask

    task automatic test_async_reset();
        do_reset();
        v4  = 4'b0010;
        or4 = 1'b1;
        step();
        v4  = 4'b1000;
        or4 = 1'b0;
        #1;
        checks++; if (idx4 !== 2'd3) begin errors++; $display("FAIL arst_grant_idx got %0d want 3", idx4); end
        step();
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL arst_lock_valid got %b want 1", ov4); end
        checks++; if (busy4 !== 1'b1) begin errors++; $display("FAIL arst_lock_busy got %b want 1", busy4); end
        #2 rst = 1'b1;
        #1;
        checks++; if (ov4 !== 1'b0) begin errors++; $display("FAIL arst_valid_drop got %b want 0", ov4); end
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL arst_busy_drop got %b want 0", busy4); end
        checks++; if (r4o !== 4'b0) begin errors++; $display("FAIL arst_ready_drop got %b want 0000", r4o); end
        #1 rst = 1'b0;
        v4 = 4'hF;
        #1;
        checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL arst_idle got busy %b want 0", busy4); end
        checks++; if (ov4 !== 1'b1) begin errors++; $display("FAIL arst_after_valid got %b want 1", ov4); end
        checks++; if (idx4 !== 2'd0) begin errors++; $display("FAIL arst_rr_cleared got idx %0d want 0", idx4); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) pay4[i] = 8'hA0 + 8'(i);
        for (int i = 0; i < 3; i++) pay3[i] = 8'hB0 + 8'(i);
        rst = 1'b1;
        gap = '0;
        v4  = '0;
        or4 = 1'b0;
        v3  = '0;
        or3 = 1'b0;
        test_reset();
        test_round_robin();
        test_lock();
        test_gap();
        test_wrap();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
